// File: rtl/aux_int_request_gen.sv
// Push-button conditioning: 2-flop sync, optional debounce, rising-edge detect, sticky req/ack/lost.
// Build option: define AUX_INT_DEBOUNCE_EN to enable the debounce counters (otherwise level follows sync).
module aux_int_request_gen #(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned DebounceCnt = 1_000_000,
  parameter int unsigned CntBit      = 20,
  parameter bit          ActiveLow   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NumIn-1:0] btn_raw,
  input  logic [NumIn-1:0] ack,
  input  logic             lost_clr,
  output logic [NumIn-1:0] req,
  output logic [NumIn-1:0] level,
  output logic [NumIn-1:0] lost
);

  if (DebounceCnt < 2 || (64'd1 << CntBit) <= 64'(DebounceCnt)) begin : g_bad_cfg
    $error("aux_int_request_gen: DebounceCnt must be >= 2 and fit in CntBit bits");
  end

  logic [NumIn-1:0] pin_s;
  logic [NumIn-1:0] s1_q, s2_q;
  logic [NumIn-1:0] stable_q, stable_d;
  logic [NumIn-1:0] rise_q, rise_d;
  logic [NumIn-1:0] req_q, req_d;
  logic [NumIn-1:0] lost_q, lost_d;

  assign pin_s = btn_raw ^ {NumIn{ActiveLow}};

`ifdef AUX_INT_DEBOUNCE_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_CNT = 1'b1} db_state_e;

  localparam logic [CntBit-1:0] CntOne  = {{(CntBit-1){1'b0}}, 1'b1};
  localparam logic [CntBit-1:0] CntLast = CntBit'(DebounceCnt - 1);

  db_state_e         state_q [NumIn];
  db_state_e         state_d [NumIn];
  logic [CntBit-1:0] cnt_q   [NumIn];
  logic [CntBit-1:0] cnt_d   [NumIn];

  // Debounce next-state: a level change is accepted only after DebounceCnt stable cycles.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NumIn; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (s2_q[i] != stable_q[i]) begin
            cnt_d[i]   = CntOne;
            state_d[i] = ST_CNT;
          end else begin
            cnt_d[i]   = '0;
          end
        end
        ST_CNT: begin
          if (s2_q[i] == stable_q[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = ST_IDLE;
          end else if (cnt_q[i] == CntLast) begin
            stable_d[i] = s2_q[i];
            cnt_d[i]    = '0;
            state_d[i]  = ST_IDLE;
          end else begin
            cnt_d[i]    = cnt_q[i] + CntOne;
          end
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Debounce state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumIn; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NumIn; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end
`else
  // Without debounce the synchronized level is accepted every cycle.
  always_comb begin
    stable_d = s2_q;
  end
`endif

  // Edge detect and request bookkeeping; a new press always wins over a concurrent ack.
  always_comb begin
    rise_d = stable_d & ~stable_q;
    req_d  = rise_q | (req_q & ~ack);
    lost_d = (rise_q & req_q & ~ack) | (lost_q & ~{NumIn{lost_clr}});
  end

  // Synchronizer, level, edge and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      req_q    <= '0;
      lost_q   <= '0;
    end else begin
      s1_q     <= pin_s;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      req_q    <= req_d;
      lost_q   <= lost_d;
    end
  end

  assign req   = req_q;
  assign level = stable_q;
  assign lost  = lost_q;

endmodule

// File: tb/tb_aux_int_request_gen.sv
// Self-checking bench for aux_int_request_gen: directed scenarios plus randomized buttons/acks
// compared every cycle against a run-length behavioural model.
module tb_aux_int_request_gen;

  localparam int NumIn = 4;
`ifdef AUX_INT_DEBOUNCE_EN
  localparam int Thresh = 4;   // consecutive differing cycles needed to accept a new level
`else
  localparam int Thresh = 1;
`endif
  localparam int Lat = Thresh + 2;  // press seen at edge 0 -> req after edge Lat

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NumIn-1:0] btn_raw, ack;
  logic             lost_clr;
  logic [NumIn-1:0] req, level, lost;

  int n_checks = 0;
  int n_fail   = 0;

  aux_int_request_gen #(
    .NumIn(NumIn), .DebounceCnt(4), .CntBit(3), .ActiveLow(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .ack(ack),
    .lost_clr(lost_clr), .req(req), .level(level), .lost(lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sync delay line, accept a level after Thresh consecutive differing samples.
  logic [NumIn-1:0] m_s1, m_s2, m_level, m_press, m_req, m_lost, old_level;
  int m_run [NumIn];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_req = '0; m_lost = '0;
      for (int i = 0; i < NumIn; i++) m_run[i] = 0;
    end else begin
      m_lost = (m_press & m_req & ~ack) | (lost_clr ? 4'h0 : m_lost);
      m_req  = m_press | (m_req & ~ack);
      old_level = m_level;
      for (int i = 0; i < NumIn; i++) begin
        if (m_s2[i] != m_level[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= Thresh) begin
            m_level[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_press = m_level & ~old_level;
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("model_req", 32'(req), 32'(m_req));
      check("model_level", 32'(level), 32'(m_level));
      check("model_lost", 32'(lost), 32'(m_lost));
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    btn_raw = '0; ack = '1; lost_clr = 1'b1;
    edges(Lat + 6);
    ack = '0; lost_clr = 1'b0;
    edges(1);
  endtask

  int hold [NumIn];

  initial begin
    rst_n = 1'b0; btn_raw = 4'hF; ack = '0; lost_clr = 1'b0;
    #3;
    check("rst_req", 32'(req), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_lost", 32'(lost), 32'h0);
    repeat (3) @(negedge clk);
    check("rst_hold_req", 32'(req), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k <= Lat + 1; k++) begin
      edges(1);
      check("latency_req", 32'(req), (k >= Lat) ? 32'hF : 32'h0);
    end
    idle();

`ifdef AUX_INT_DEBOUNCE_EN
    btn_raw[0] = 1'b1;
    edges(3);
    btn_raw[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      edges(1);
      check("glitch_ch0", 32'({level[0], req[0]}), 32'h0);
    end
`else
    btn_raw[0] = 1'b1;
    edges(1);
    btn_raw[0] = 1'b0;
    edges(2);
    check("pulse_before", 32'(req[0]), 32'h0);
    edges(1);
    check("pulse_req", 32'(req[0]), 32'h1);
`endif
    idle();

    btn_raw[1] = 1'b1;
    edges(Lat + 1);
    check("ack_press", 32'(req[1]), 32'h1);
    ack[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      edges(1);
      check("ack_held", 32'(req[1]), 32'h0);
    end
    ack[1] = 1'b0;
    edges(2);
    check("ack_after", 32'(req[1]), 32'h0);
    btn_raw[1] = 1'b0;
    edges(Lat + 3);
    btn_raw[1] = 1'b1;
    edges(Lat + 1);
    check("repress", 32'(req[1]), 32'h1);
    idle();

    btn_raw[2] = 1'b1;
    edges(Lat + 1);
    btn_raw[2] = 1'b0;
    edges(Lat + 3);
    check("lost_none", 32'(lost[2]), 32'h0);
    btn_raw[2] = 1'b1;
    edges(Lat + 1);
    check("lost_req", 32'(req[2]), 32'h1);
    check("lost_set", 32'(lost[2]), 32'h1);
    lost_clr = 1'b1;
    edges(1);
    lost_clr = 1'b0;
    check("lost_clr", 32'(lost[2]), 32'h0);
    check("lost_clr_req", 32'(req[2]), 32'h1);
    idle();

    ack[3] = 1'b1; btn_raw[3] = 1'b1;
    edges(Lat + 1);
    check("rise_ack_req", 32'(req[3]), 32'h1);
    check("rise_ack_lost", 32'(lost[3]), 32'h0);
    edges(1);
    check("rise_ack_clear", 32'(req[3]), 32'h0);
    ack = '0; btn_raw = '0;
    edges(Lat + 3);
    btn_raw = 4'h9;
    edges(Lat);
    check("simul_before", 32'(req & 4'h9), 32'h0);
    edges(1);
    check("simul_both", 32'(req & 4'h9), 32'h9);
    idle();

    for (int i = 0; i < NumIn; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NumIn; i++) begin
        if (hold[i] == 0) begin
          btn_raw[i] = ($urandom_range(0, 1) == 1);
          hold[i] = $urandom_range(1, 9);
        end else begin
          hold[i] = hold[i] - 1;
        end
        ack[i] = ($urandom_range(0, 7) == 0);
      end
      lost_clr = ($urandom_range(0, 15) == 0);
      if (c == 1500) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst", 32'({req, level, lost}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      edges(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
